// File: rtl/operand_fetch_pkg.sv
// Shared core definitions for the operand fetch slice: sizes, FSM state
// encoding and the latched request record.
package rv_core_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 2 ** REG_AW;

    localparam logic [REG_AW-1:0] REG_X0 = {REG_AW{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } opfetch_state_t;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              rd_wen;
        logic [XLEN-1:0]   pc;
    } fetch_req_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Decode/regfile/writeback/execute signal bundle around operand_fetch.
// slave is the operand_fetch side, master is the surrounding pipeline.
interface operand_fetch_if;
    import rv_core_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_rs1;
    logic [REG_AW-1:0] in_rs2;
    logic [REG_AW-1:0] in_rd;
    logic              in_rd_wen;
    logic [XLEN-1:0]   in_pc;
    logic [REG_AW-1:0] rf_rs1;
    logic [REG_AW-1:0] rf_rs2;
    logic [XLEN-1:0]   rf_rs1_data;
    logic [XLEN-1:0]   rf_rs2_data;
    logic              rf_wen;
    logic [REG_AW-1:0] rf_rd;
    logic [XLEN-1:0]   rf_rd_data;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_rs1_data;
    logic [XLEN-1:0]   out_rs2_data;
    logic [REG_AW-1:0] out_rd;
    logic              out_rd_wen;
    logic [XLEN-1:0]   out_pc;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_wen, in_pc,
        input  rf_rs1_data, rf_rs2_data, wb_valid, wb_rd, wb_data, out_ready,
        output in_ready, rf_rs1, rf_rs2, rf_wen, rf_rd, rf_rd_data,
        output out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_wen, out_pc
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_wen, in_pc,
        output rf_rs1_data, rf_rs2_data, wb_valid, wb_rd, wb_data, out_ready,
        input  in_ready, rf_rs1, rf_rs2, rf_wen, rf_rd, rf_rd_data,
        input  out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_wen, out_pc
    );

endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write scoreboard: one bit per register, x0 never pending.
// Set and clear may target different registers in the same cycle.
module reg_scoreboard
    import rv_core_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_idx,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_idx,
    input  logic [REG_AW-1:0] qa_idx,
    input  logic [REG_AW-1:0] qb_idx,
    input  logic [REG_AW-1:0] qc_idx,
    output logic              qa,
    output logic              qb,
    output logic              qc
);

    localparam logic [NUM_REGS-1:0] BIT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

    logic [NUM_REGS-1:0] pending_r;
    logic [NUM_REGS-1:0] set_mask_s;
    logic [NUM_REGS-1:0] clr_mask_s;
    logic [NUM_REGS-1:0] pending_next_s;

    assign set_mask_s     = set_en ? (BIT0 << set_idx) : {NUM_REGS{1'b0}};
    assign clr_mask_s     = clr_en ? (BIT0 << clr_idx) : {NUM_REGS{1'b0}};
    assign pending_next_s = ((pending_r & ~clr_mask_s) | set_mask_s) & ~BIT0;

    // Pending bit register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= {NUM_REGS{1'b0}};
        end else begin
            pending_r <= pending_next_s;
        end
    end

    assign qa = pending_r[qa_idx];
    assign qb = pending_r[qb_idx];
    assign qc = pending_r[qc_idx];

endmodule

// File: rtl/operand_fetch.sv
// Register-file operand fetch with RAW/WAW scoreboard stall.
// Optional writeback-to-operand bypass: define OPERAND_FETCH_BYPASS_EN.
module operand_fetch
    import rv_core_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    operand_fetch_if.slave  bus
);

    opfetch_state_t  state_r;
    opfetch_state_t  next_state_s;
    fetch_req_t      req_r;
    logic [XLEN-1:0] hold_rs1_r;
    logic [XLEN-1:0] hold_rs2_r;
    logic [XLEN-1:0] opnd_rs1_s;
    logic [XLEN-1:0] opnd_rs2_s;
    logic            pend_rs1_s;
    logic            pend_rs2_s;
    logic            pend_rd_s;
    logic            byp_hit_rs1_s;
    logic            byp_hit_rs2_s;
    logic            byp_sel_rs1_s;
    logic            byp_sel_rs2_s;
    logic [XLEN-1:0] byp_rs1_s;
    logic [XLEN-1:0] byp_rs2_s;
    logic            hazard_s;
    logic            out_fire_s;
    logic            accept_s;
    logic            set_en_s;

    reg_scoreboard u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (set_en_s),
        .set_idx (bus.in_rd),
        .clr_en  (bus.wb_valid),
        .clr_idx (bus.wb_rd),
        .qa_idx  (bus.in_rs1),
        .qb_idx  (bus.in_rs2),
        .qc_idx  (bus.in_rd),
        .qa      (pend_rs1_s),
        .qb      (pend_rs2_s),
        .qc      (pend_rd_s)
    );

`ifdef OPERAND_FETCH_BYPASS_EN
    logic            byp_flag_rs1_r;
    logic            byp_flag_rs2_r;
    logic [XLEN-1:0] byp_data_rs1_r;
    logic [XLEN-1:0] byp_data_rs2_r;

    assign byp_hit_rs1_s = bus.wb_valid && (bus.wb_rd == bus.in_rs1);
    assign byp_hit_rs2_s = bus.wb_valid && (bus.wb_rd == bus.in_rs2);

    // Capture the concurrent writeback result for sources whose hazard was waived
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_flag_rs1_r <= 1'b0;
            byp_flag_rs2_r <= 1'b0;
            byp_data_rs1_r <= {XLEN{1'b0}};
            byp_data_rs2_r <= {XLEN{1'b0}};
        end else if (accept_s) begin
            byp_flag_rs1_r <= byp_hit_rs1_s;
            byp_flag_rs2_r <= byp_hit_rs2_s;
            byp_data_rs1_r <= bus.wb_data;
            byp_data_rs2_r <= bus.wb_data;
        end
    end

    assign byp_sel_rs1_s = byp_flag_rs1_r;
    assign byp_sel_rs2_s = byp_flag_rs2_r;
    assign byp_rs1_s     = byp_data_rs1_r;
    assign byp_rs2_s     = byp_data_rs2_r;
`else
    assign byp_hit_rs1_s = 1'b0;
    assign byp_hit_rs2_s = 1'b0;
    assign byp_sel_rs1_s = 1'b0;
    assign byp_sel_rs2_s = 1'b0;
    assign byp_rs1_s     = {XLEN{1'b0}};
    assign byp_rs2_s     = {XLEN{1'b0}};
`endif

    // rd hazards (WAW) are never waived by the bypass
    assign hazard_s = ((bus.in_rs1 != REG_X0) && pend_rs1_s && !byp_hit_rs1_s) ||
                      ((bus.in_rs2 != REG_X0) && pend_rs2_s && !byp_hit_rs2_s) ||
                      (bus.in_rd_wen && (bus.in_rd != REG_X0) && pend_rd_s);

    assign bus.out_valid = (state_r != IDLE);
    assign out_fire_s    = bus.out_valid && bus.out_ready;
    assign bus.in_ready  = ((state_r == IDLE) || out_fire_s) && !hazard_s;
    assign accept_s      = bus.in_valid && bus.in_ready;
    assign set_en_s      = accept_s && bus.in_rd_wen && (bus.in_rd != REG_X0);

    assign bus.rf_rs1     = accept_s ? bus.in_rs1 : REG_X0;
    assign bus.rf_rs2     = accept_s ? bus.in_rs2 : REG_X0;
    assign bus.rf_wen     = bus.wb_valid && (bus.wb_rd != REG_X0);
    assign bus.rf_rd      = bus.wb_rd;
    assign bus.rf_rd_data = bus.wb_data;

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) next_state_s = READ;
                else          next_state_s = IDLE;
            end
            READ, HOLD: begin
                if (out_fire_s) next_state_s = accept_s ? READ : IDLE;
                else            next_state_s = HOLD;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Operand select: live read data in READ, holding registers otherwise
    always_comb begin
        opnd_rs1_s = hold_rs1_r;
        opnd_rs2_s = hold_rs2_r;
        if (state_r == READ) begin
            if (req_r.rs1 == REG_X0) opnd_rs1_s = {XLEN{1'b0}};
            else if (byp_sel_rs1_s)  opnd_rs1_s = byp_rs1_s;
            else                     opnd_rs1_s = bus.rf_rs1_data;
            if (req_r.rs2 == REG_X0) opnd_rs2_s = {XLEN{1'b0}};
            else if (byp_sel_rs2_s)  opnd_rs2_s = byp_rs2_s;
            else                     opnd_rs2_s = bus.rf_rs2_data;
        end else begin
            opnd_rs1_s = hold_rs1_r;
            opnd_rs2_s = hold_rs2_r;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= next_state_s;
    end

    // Request latch on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_r <= '{rs1: REG_X0, rs2: REG_X0, rd: REG_X0, rd_wen: 1'b0, pc: {XLEN{1'b0}}};
        end else if (accept_s) begin
            req_r <= '{rs1: bus.in_rs1, rs2: bus.in_rs2, rd: bus.in_rd,
                       rd_wen: bus.in_rd_wen, pc: bus.in_pc};
        end
    end

    // Operand holding registers, refreshed every READ cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_rs1_r <= {XLEN{1'b0}};
            hold_rs2_r <= {XLEN{1'b0}};
        end else if (state_r == READ) begin
            hold_rs1_r <= opnd_rs1_s;
            hold_rs2_r <= opnd_rs2_s;
        end
    end

    assign bus.out_rs1_data = opnd_rs1_s;
    assign bus.out_rs2_data = opnd_rs2_s;
    assign bus.out_rd       = req_r.rd;
    assign bus.out_rd_wen   = req_r.rd_wen;
    assign bus.out_pc       = req_r.pc;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a synchronous-read register file model.
module tb_operand_fetch;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] mem [32];
    logic [31:0] rd1_r;
    logic [31:0] rd2_r;

    operand_fetch_if ifc ();

    operand_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: write and read on the same edge return old data
    always @(posedge clk) begin
        if (ifc.rf_wen) mem[ifc.rf_rd] <= ifc.rf_rd_data;
        rd1_r <= mem[ifc.rf_rs1];
        rd2_r <= mem[ifc.rf_rs2];
    end

    assign ifc.rf_rs1_data = rd1_r;
    assign ifc.rf_rs2_data = rd2_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic wen, input logic [31:0] pc);
        ifc.in_valid  = 1'b1;
        ifc.in_rs1    = rs1;
        ifc.in_rs2    = rs2;
        ifc.in_rd     = rd;
        ifc.in_rd_wen = wen;
        ifc.in_pc     = pc;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] data);
        ifc.wb_valid = v;
        ifc.wb_rd    = rd;
        ifc.wb_data  = data;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        issue(5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        ifc.in_valid  = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        ifc.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);
        chk("rst_out_rs1", ifc.out_rs1_data, 32'h0);
        chk("rst_out_rd", {27'd0, ifc.out_rd}, 32'd0);
        chk("rst_out_pc", ifc.out_pc, 32'h0);
        chk("rst_rf_wen", {31'd0, ifc.rf_wen}, 32'd0);
        rst = 1'b0;

        // Preload x1/x2 through the writeback port
        wb(1'b1, 5'd1, 32'h11);
        #1 chk("pre_rf_wen", {31'd0, ifc.rf_wen}, 32'd1);
        tick;
        wb(1'b1, 5'd2, 32'h22);
        tick;
        wb(1'b0, 5'd0, 32'h0);

        // Basic read
        issue(5'd1, 5'd2, 5'd3, 1'b1, 32'h100);
        #1 chk("basic_in_ready", {31'd0, ifc.in_ready}, 32'd1);
        chk("basic_rf_rs1", {27'd0, ifc.rf_rs1}, 32'd1);
        chk("basic_rf_rs2", {27'd0, ifc.rf_rs2}, 32'd2);
        tick;
        issue(5'd3, 5'd0, 5'd0, 1'b0, 32'h0);
        #1 chk("basic_out_valid", {31'd0, ifc.out_valid}, 32'd1);
        chk("basic_rs1", ifc.out_rs1_data, 32'h11);
        chk("basic_rs2", ifc.out_rs2_data, 32'h22);
        chk("basic_rd", {27'd0, ifc.out_rd}, 32'd3);
        chk("basic_rd_wen", {31'd0, ifc.out_rd_wen}, 32'd1);
        chk("basic_pc", ifc.out_pc, 32'h100);
        chk("pend3_stall", {31'd0, ifc.in_ready}, 32'd0);
        chk("noacc_rf_rs1", {27'd0, ifc.rf_rs1}, 32'd0);
        ifc.in_valid = 1'b0;
        tick;
        chk("basic_idle", {31'd0, ifc.out_valid}, 32'd0);
        wb(1'b1, 5'd3, 32'h33);
        tick;
        wb(1'b0, 5'd0, 32'h0);

        // x0 handling: read x0, write x0 ignored
        issue(5'd0, 5'd1, 5'd0, 1'b1, 32'h104);
        wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        #1 chk("x0_rf_wen", {31'd0, ifc.rf_wen}, 32'd0);
        chk("x0_in_ready", {31'd0, ifc.in_ready}, 32'd1);
        tick;
        ifc.in_valid = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        #1 chk("x0_rs1", ifc.out_rs1_data, 32'h0);
        chk("x0_rs2", ifc.out_rs2_data, 32'h11);
        tick;

        // RAW stall on x5
        issue(5'd1, 5'd2, 5'd5, 1'b1, 32'h200);
        tick;
        issue(5'd5, 5'd0, 5'd6, 1'b1, 32'h204);
        #1 chk("raw_stall_a", {31'd0, ifc.in_ready}, 32'd0);
        chk("raw_a_pc", ifc.out_pc, 32'h200);
        tick;
        chk("raw_stall_b", {31'd0, ifc.in_ready}, 32'd0);
        wb(1'b1, 5'd5, 32'hAB);
`ifdef OPERAND_FETCH_BYPASS_EN
        #1 chk("raw_byp_accept", {31'd0, ifc.in_ready}, 32'd1);
        tick;
        wb(1'b0, 5'd0, 32'h0);
        ifc.in_valid = 1'b0;
`else
        #1 chk("raw_wb_cycle_stall", {31'd0, ifc.in_ready}, 32'd0);
        tick;
        wb(1'b0, 5'd0, 32'h0);
        #1 chk("raw_accept", {31'd0, ifc.in_ready}, 32'd1);
        tick;
        ifc.in_valid = 1'b0;
`endif
        #1 chk("raw_out_valid", {31'd0, ifc.out_valid}, 32'd1);
        chk("raw_rs1", ifc.out_rs1_data, 32'hAB);
        chk("raw_pc", ifc.out_pc, 32'h204);
        tick;
        wb(1'b1, 5'd6, 32'h66);
        tick;
        wb(1'b0, 5'd0, 32'h0);

        // Backpressure with an unrelated writeback
        ifc.out_ready = 1'b0;
        issue(5'd1, 5'd2, 5'd8, 1'b1, 32'h300);
        tick;
        ifc.in_valid = 1'b0;
        wb(1'b1, 5'd7, 32'h77);
        #1 chk("bp_read_rs1", ifc.out_rs1_data, 32'h11);
        tick;
        wb(1'b0, 5'd0, 32'h0);
        #1 chk("bp_hold_valid", {31'd0, ifc.out_valid}, 32'd1);
        chk("bp_hold_rs1", ifc.out_rs1_data, 32'h11);
        chk("bp_hold_rs2", ifc.out_rs2_data, 32'h22);
        chk("bp_hold_pc", ifc.out_pc, 32'h300);
        tick;
        chk("bp_hold2_rs1", ifc.out_rs1_data, 32'h11);
        chk("bp_hold2_rs2", ifc.out_rs2_data, 32'h22);
        ifc.out_ready = 1'b1;
        #1 chk("bp_release_valid", {31'd0, ifc.out_valid}, 32'd1);
        tick;
        chk("bp_idle", {31'd0, ifc.out_valid}, 32'd0);
        tick;
        chk("bp_single", {31'd0, ifc.out_valid}, 32'd0);
        wb(1'b1, 5'd8, 32'h88);
        tick;
        wb(1'b0, 5'd0, 32'h0);

        // Back-to-back independent instructions
        issue(5'd1, 5'd7, 5'd9, 1'b1, 32'h400);
        tick;
        for (int i = 1; i < 4; i++) begin
            issue(5'd1, 5'd7, 5'(9 + i), 1'b1, 32'h400 + 32'(4 * i));
            #1 chk("b2b_in_ready", {31'd0, ifc.in_ready}, 32'd1);
            chk("b2b_pc", ifc.out_pc, 32'h400 + 32'(4 * (i - 1)));
            chk("b2b_rs2", ifc.out_rs2_data, 32'h77);
            tick;
        end
        ifc.in_valid = 1'b0;
        #1 chk("b2b_last_valid", {31'd0, ifc.out_valid}, 32'd1);
        chk("b2b_last_pc", ifc.out_pc, 32'h40C);
        tick;
        chk("b2b_idle", {31'd0, ifc.out_valid}, 32'd0);

        // Reset during HOLD with x5 pending
        ifc.out_ready = 1'b0;
        issue(5'd1, 5'd2, 5'd5, 1'b1, 32'h500);
        tick;
        ifc.in_valid = 1'b0;
        tick;
        chk("mrst_hold_valid", {31'd0, ifc.out_valid}, 32'd1);
        rst = 1'b1;
        #1 chk("mrst_valid_drop", {31'd0, ifc.out_valid}, 32'd0);
        tick;
        rst = 1'b0;
        ifc.out_ready = 1'b1;
        issue(5'd5, 5'd1, 5'd13, 1'b1, 32'h600);
        #1 chk("mrst_accept", {31'd0, ifc.in_ready}, 32'd1);
        tick;
        ifc.in_valid = 1'b0;
        #1 chk("mrst_out_valid", {31'd0, ifc.out_valid}, 32'd1);
        chk("mrst_rs1", ifc.out_rs1_data, 32'hAB);
        chk("mrst_rs2", ifc.out_rs2_data, 32'h11);
        chk("mrst_pc", ifc.out_pc, 32'h600);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

- Issue-side front end of the integer register file: accepts decoded instructions, drives the file's read addresses, and returns both source operands one cycle later.
- Owns the file's write port and tracks pending destination writes with a scoreboard, so RAW and WAW hazards stall at the input.
- Sits between decode and execute; writeback returns results to it.

## Interface
- XLEN, 32, operand and data width
- REG_AW, 5, register address width (2**REG_AW registers, x0 hardwired zero)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  instruction accepted when in_valid && in_ready
- in_rs1, in_rs2  in  REG_AW  source register numbers
- in_rd  in  REG_AW  destination register
- in_rd_wen  in  1  instruction writes in_rd
- in_pc  in  XLEN  sideband, passed through unchanged
- rf_rs1, rf_rs2  out  REG_AW  register file read addresses; read data returns next cycle
- rf_rs1_data, rf_rs2_data  in  XLEN  register file read data
- rf_wen, rf_rd  out  1, REG_AW  register file write enable and write address
- rf_rd_data  out  XLEN  register file write data
- wb_valid, wb_rd, wb_data  in  1, REG_AW, XLEN  writeback result
- out_valid  out  1  operands valid
- out_ready  in  1  execute accepts when out_valid && out_ready
- out_rs1_data, out_rs2_data  out  XLEN  source operands
- out_rd, out_rd_wen, out_pc  out  REG_AW, 1, XLEN  passed-through fields

## Operation
- **FSM states:** IDLE, READ, HOLD. Reset enters IDLE.
- **Accepting an instruction:**
  - in_ready = (IDLE || (out_valid && out_ready)) && !hazard.
  - hazard = (rs1≠0 && pending[rs1]) || (rs2≠0 && pending[rs2]) || (in_rd_wen && rd≠0 && pending[rd]).
  - On accept, latch rs1/rs2/rd/rd_wen/pc, go to READ, and set pending[rd] if in_rd_wen && rd≠0.
- **Read addresses:** rf_rs1/rf_rs2 = in_rs1/in_rs2 combinationally. Drive 0 when no accept occurs.
- **READ:**
  - out_valid=1.
  - Operand = 0 if its register is x0, else the bypass capture if flagged, else rf data.
  - Always latch operands into holding registers.
  - out fire → next state is READ if a new instruction is accepted, else IDLE; no fire → HOLD.
- **HOLD:** out_valid=1; operands come from the holding registers; leave on out fire, same next-state rule as READ.
- **Writeback:**
  - rf_wen = wb_valid && wb_rd≠0; rf_rd = wb_rd; rf_rd_data = wb_data (combinational).
  - wb_valid clears pending[wb_rd].
  - Writeback to x0 is ignored.
- **Simultaneous events:** set and clear of the same bit in one cycle cannot occur, because rd pending stalls the accept. Sources of an in-flight instruction are never pending, so READ/HOLD operands need no further update.
- **Reset values:**
  - out_valid 0; in_ready 1 (empty scoreboard).
  - Scoreboard all 0.
  - out_* data and fields 0; rf_wen 0.
  - Register file contents are not reset.

## Timing
- Accept at edge T → out_valid during cycle T+1.
- Throughput is one instruction per cycle while out_ready=1 and there are no hazards.
- Writeback at edge W clears the pending bit. Without bypass, a stalled dependent is accepted at the earliest in cycle W+1, and its read returns the new value.
- Same-cycle regfile write and read return old data; the block never relies on that ordering.
- rst asserted mid-operation immediately forces IDLE, drops out_valid and clears the scoreboard. The in-flight instruction is discarded.

## Configuration
- **OPERAND_FETCH_BYPASS_EN defined:**
  - A source hazard is waived when wb_valid && wb_rd equals that source in the same cycle.
  - The instruction is accepted; wb_data is captured into a per-operand bypass register, and a flag selects it in READ.
  - rd hazards are never waived.
- **Undefined:** no bypass registers; the dependent instruction stalls one extra cycle.

## Structure
- Shared package `rv_core_pkg` holds:
  - XLEN, REG_AW and NUM_REGS constants;
  - the `opfetch_state_t` enum (IDLE/READ/HOLD);
  - the `fetch_req_t` struct (rs1, rs2, rd, rd_wen, pc).
- One sub-module, `reg_scoreboard`:
  - NUM_REGS pending bits with a set port and a clear port;
  - three combinational query ports;
  - bit 0 tied to 0.

## Test plan
- **Basic read:** preload x1=0x11, x2=0x22; accept rs1=1, rs2=2, rd=3 → out_valid next cycle with 0x11/0x22, out_rd=3, pending[3]=1.
- **x0 handling:** rs1=0, plus wb_valid rd=0 data 0xFFFF_FFFF → out_rs1_data=0, rf_wen=0.
- **RAW stall:** A (rd=5) issued; B (rs1=5) holds in_ready=0; wb rd=5 data 0xAB in cycle W.
  - Bypass build: B accepted in W, out_rs1_data=0xAB.
  - Non-bypass build: B accepted in W+1, same value.
- **Backpressure:** out_ready=0 for 3 cycles while wb writes x7=0x77 (unrelated) → outputs stable in HOLD; release → single transfer, then IDLE.
- **Back-to-back:** 4 independent instructions with out_ready=1 → 4 outputs on 4 consecutive cycles, pc order preserved.
- **Reset mid-operation:** assert rst during HOLD with pending[5]=1 → out_valid drops immediately; after release, an instruction with rs1=5 is accepted at once.
